// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin memory arbiter.
// The optional MEM_CLEAR_EN build uses the CLEAR state to zero memory after reset.
package mem_arb_pkg;

  localparam int NBITS_ADDR_DEF = 2;
  localparam int NBITS_DATA_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // On a tie, the requester that was not served last wins.
  function automatic req_id_t pick_winner(input logic ra, input logic rb, input req_id_t last);
    if (ra && rb) return (last == REQ_A) ? REQ_B : REQ_A;
    else if (ra)  return REQ_A;
    else          return REQ_B;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Per-requester command/response bundle between a client and mem_arbiter_rr.
// One instance per requester; the client uses master, the arbiter uses slave.
interface mem_arbiter_rr_if #(
  parameter int NBITS_ADDR = 2,
  parameter int NBITS_DATA = 4
) ();

  // req/gnt: the client holds req, we, addr and wdata stable until it sees gnt;
  // req still high in the cycle after gnt is a new request. rvalid pulses for one
  // cycle (reads only), and rdata is zero whenever rvalid is low.
  logic                  req;
  logic                  we;
  logic [NBITS_ADDR-1:0] addr;
  logic [NBITS_DATA-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [NBITS_DATA-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_sync_rw.sv
// Single-port synchronous memory with a registered read; the array has no reset.
module mem_sync_rw #(
  parameter int NBITS_ADDR = 2,
  parameter int NBITS_DATA = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NBITS_ADDR-1:0] addr,
  input  logic [NBITS_DATA-1:0] wdata,
  output logic [NBITS_DATA-1:0] rdata
);

  logic [NBITS_DATA-1:0] mem [0:(1<<NBITS_ADDR)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one synchronous memory between requesters A and B.
// Define MEM_CLEAR_EN to zero the whole memory in a CLEAR state after every reset.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NBITS_ADDR = NBITS_ADDR_DEF,
  parameter int NBITS_DATA = NBITS_DATA_DEF
) (
  input  logic                   clk_2,
  input  logic                   reset,
  mem_arbiter_rr_if.slave        port_a,
  mem_arbiter_rr_if.slave        port_b,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  state_t                state;
  req_id_t               last;
  req_id_t               winner;
  req_id_t               pick;
  logic                  cap_we;
  logic [NBITS_ADDR-1:0] cap_addr;
  logic [NBITS_DATA-1:0] cap_wdata;
  logic                  gnt_a_q, gnt_b_q;
  logic                  rvalid_a_q, rvalid_b_q;

  logic                  mem_we;
  logic [NBITS_ADDR-1:0] mem_addr;
  logic [NBITS_DATA-1:0] mem_wdata;
  logic [NBITS_DATA-1:0] mem_rdata;

`ifdef MEM_CLEAR_EN
  logic [NBITS_ADDR-1:0] clr_cnt;
`endif

  always_comb pick = pick_winner(port_a.req, port_b.req, last);

  always_ff @(posedge clk_2) begin
    if (reset) begin
`ifdef MEM_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      last       <= REQ_B;
      winner     <= REQ_A;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      case (state)
        IDLE: begin
          if (port_a.req || port_b.req) begin
            winner    <= pick;
            cap_we    <= (pick == REQ_A) ? port_a.we    : port_b.we;
            cap_addr  <= (pick == REQ_A) ? port_a.addr  : port_b.addr;
            cap_wdata <= (pick == REQ_A) ? port_a.wdata : port_b.wdata;
            gnt_a_q   <= (pick == REQ_A);
            gnt_b_q   <= (pick == REQ_B);
            state     <= SERVE;
          end
        end
        SERVE: begin
          last       <= winner;
          rvalid_a_q <= !cap_we && (winner == REQ_A);
          rvalid_b_q <= !cap_we && (winner == REQ_B);
          state      <= IDLE;
        end
`ifdef MEM_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Gating the write with reset makes a reset during SERVE abort the commit.
  always_comb begin
    mem_we    = (state == SERVE) && cap_we && !reset;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) begin
      mem_we    = !reset;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end
`endif
  end

  mem_sync_rw #(
    .NBITS_ADDR(NBITS_ADDR),
    .NBITS_DATA(NBITS_DATA)
  ) u_mem (
    .clk   (clk_2),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign port_a.gnt    = gnt_a_q;
  assign port_b.gnt    = gnt_b_q;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.rvalid = rvalid_b_q;
  assign port_a.rdata  = rvalid_a_q ? mem_rdata : '0;
  assign port_b.rdata  = rvalid_b_q ? mem_rdata : '0;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr (default build): directed steps, then
// random traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter_rr;

  localparam int AW    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk_2 = ~clk_2;

  mem_arbiter_rr_if #(.NBITS_ADDR(AW), .NBITS_DATA(DW)) port_a ();
  mem_arbiter_rr_if #(.NBITS_ADDR(AW), .NBITS_DATA(DW)) port_b ();

  mem_arbiter_rr #(.NBITS_ADDR(AW), .NBITS_DATA(DW)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .port_a    (port_a),
    .port_b    (port_b),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Reference model: memory image, round-robin history, one in-flight access.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_last;
  bit            m_prev_serve;
  bit            pend_v;
  int            pend_id;
  bit            pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wdata;
  logic [DW-1:0] exp_q_a [$];
  logic [DW-1:0] exp_q_b [$];
  int            m_win;

  // Inputs as seen by the DUT at the rising edge being modelled.
  logic          s_reset, s_req_a, s_req_b, s_we_a, s_we_b;
  logic [AW-1:0] s_addr_a, s_addr_b;
  logic [DW-1:0] s_wdata_a, s_wdata_b;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_and_check();
    logic          ev_a, ev_b;
    logic [DW-1:0] ed_a, ed_b;
    m_win = -1;
    if (s_reset) begin
      pend_v       = 0;
      m_prev_serve = 0;
      m_last       = 1;
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      if (pend_v) begin
        if (pend_we)           m_mem[pend_addr] = pend_wdata;
        else if (pend_id == 0) exp_q_a.push_back(m_mem[pend_addr]);
        else                   exp_q_b.push_back(m_mem[pend_addr]);
        pend_v = 0;
      end
      if (!m_prev_serve) begin
        if (s_req_a && s_req_b) m_win = 1 - m_last;
        else if (s_req_a)       m_win = 0;
        else if (s_req_b)       m_win = 1;
      end
      if (m_win >= 0) begin
        pend_v     = 1;
        pend_id    = m_win;
        pend_we    = (m_win == 0) ? s_we_a    : s_we_b;
        pend_addr  = (m_win == 0) ? s_addr_a  : s_addr_b;
        pend_wdata = (m_win == 0) ? s_wdata_a : s_wdata_b;
        m_last     = m_win;
      end
      m_prev_serve = (m_win >= 0);
    end
    ev_a = (exp_q_a.size() > 0);
    ev_b = (exp_q_b.size() > 0);
    ed_a = ev_a ? exp_q_a.pop_front() : '0;
    ed_b = ev_b ? exp_q_b.pop_front() : '0;
    check("gnt_a",     {7'd0, port_a.gnt},    {7'd0, m_win == 0});
    check("gnt_b",     {7'd0, port_b.gnt},    {7'd0, m_win == 1});
    check("rvalid_a",  {7'd0, port_a.rvalid}, {7'd0, ev_a});
    check("rvalid_b",  {7'd0, port_b.rvalid}, {7'd0, ev_b});
    check("rdata_a",   {4'd0, port_a.rdata},  {4'd0, ed_a});
    check("rdata_b",   {4'd0, port_b.rdata},  {4'd0, ed_b});
    check("busy",      {7'd0, busy},          {7'd0, m_win >= 0});
    check("dbg_state", {6'd0, dbg_state},     (m_win >= 0) ? 8'd1 : 8'd0);
  endtask

  task automatic tick();
    s_reset   = reset;
    s_req_a   = port_a.req;   s_req_b   = port_b.req;
    s_we_a    = port_a.we;    s_we_b    = port_b.we;
    s_addr_a  = port_a.addr;  s_addr_b  = port_b.addr;
    s_wdata_a = port_a.wdata; s_wdata_b = port_b.wdata;
    @(posedge clk_2);
    @(negedge clk_2);
    model_and_check();
  endtask

  task automatic drive(input int id, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (id == 0) begin
      port_a.req = req; port_a.we = we; port_a.addr = addr; port_a.wdata = wdata;
    end else begin
      port_b.req = req; port_b.we = we; port_b.addr = addr; port_b.wdata = wdata;
    end
  endtask

  // One complete access: request until granted, drop req, then the response cycle.
  task automatic access(input int id, input bit we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit got = 0;
    int n   = 0;
    drive(id, 1'b1, we, addr, wdata);
    while (!got && n < 8) begin
      tick();
      n++;
      got = (id == 0) ? port_a.gnt : port_b.gnt;
    end
    check("grant_seen", {7'd0, got}, 8'd1);
    drive(id, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n_a, n_b;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    m_last = 1;
    m_prev_serve = 0;
    pend_v = 0;

    // Reset state
    do_reset();
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_dbg",  {6'd0, dbg_state}, 8'd0);

    // Give every location a known value
    for (int i = 0; i < DEPTH; i++) access(i % 2, 1'b1, AW'(i), DW'(i + 3));

    // A writes 2 <- 0xA, then reads it back
    access(0, 1'b1, 2'd2, 4'hA);
    access(0, 1'b0, 2'd2, 4'h0);
    check("rd_a_addr2", {4'd0, port_a.rdata}, 8'h0A);

    // Both held after reset: strict alternation starting with A
    do_reset();
    drive(0, 1'b1, 1'b0, 2'd0, 4'h0);
    drive(1, 1'b1, 1'b0, 2'd1, 4'h0);
    n_a = 0;
    n_b = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) check("first_gnt_a", {7'd0, port_a.gnt}, 8'd1);
      check("gnt_exclusive", {7'd0, port_a.gnt && port_b.gnt}, 8'd0);
      n_a += int'(port_a.gnt);
      n_b += int'(port_b.gnt);
    end
    check("alt_count_a", 8'(n_a), 8'd2);
    check("alt_count_b", 8'(n_b), 8'd2);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // B writes 1 <- 0x5, A reads it
    access(1, 1'b1, 2'd1, 4'h5);
    access(0, 1'b0, 2'd1, 4'h0);
    check("rd_a_addr1", {4'd0, port_a.rdata}, 8'h05);

    // Reset during SERVE of a write aborts the commit
    access(0, 1'b1, 2'd3, 4'h6);
    drive(0, 1'b1, 1'b1, 2'd3, 4'hF);
    tick();
    check("serve_before_rst", {7'd0, port_a.gnt}, 8'd1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    reset = 1'b0;
    tick();
    access(0, 1'b0, 2'd3, 4'h0);
    check("rd_after_abort", {4'd0, port_a.rdata}, 8'h06);

    // A request pulsed only while B is in SERVE is lost
    drive(1, 1'b1, 1'b0, 2'd1, 4'h0);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b1, 1'b0, 2'd2, 4'h0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    check("lost_req_gnt_a", {7'd0, port_a.gnt}, 8'd0);
    check("lost_req_idle",  {7'd0, busy}, 8'd0);

    // Random traffic obeying the handshake
    for (int c = 0; c < 400; c++) begin
      if (!port_a.req || port_a.gnt)
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 15)));
      if (!port_b.req || port_b.gnt)
        drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 15)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
